insn_buffer: RTL and testbench
==============================

INSN_BUFFER -- requirements
Module: insn_buffer

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 128, meaning I-cache line width in bits (power of 2, >=64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning instruction queue entries (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports fetchValid in 1, fetchFault in 1, fetchPc in 32, fetchLine in LINE_WIDTH, meaning the fetch beat.
REQ-006 SHALL have port fetchStall  out  1  backpressure to fetch; a beat presented while high is not consumed and is re-presented later.
REQ-007 SHALL have port flush  in  1  discard all buffered and held state.
REQ-008 SHALL have ports outValid out 1, outReady in 1, outPc out 32, outInsn out 32, outFault out 1, meaning the decode-side queue head.

Function
REQ-009 SHALL accept a beat when fetchValid && !fetchStall && !flush, and ignore it otherwise.
REQ-010 SHALL drive fetchStall = (count == DEPTH), from registered state only; a push is refused when full even if a pop occurs that cycle.
REQ-011 SHALL take halfword h0 at byte offset fetchPc[log2(LINE_WIDTH/8)-1:1] and h1 as the next halfword of the same line.
REQ-012 SHALL push {fetchPc, {h1,h0}, 0} when h0[1:0]==2'b11 and h0 is not the line's last halfword.
REQ-013 SHALL push {fetchPc, {16'h0,h0}, 0} when h0[1:0]!=2'b11, including the last halfword.
REQ-014 SHALL push nothing when h0[1:0]==2'b11 and h0 is the line's last halfword; it SHALL instead set heldValid and register heldHalf=h0 and heldPc=fetchPc.
REQ-015 SHALL, when heldValid and the accepted beat has fetchPc==heldPc+2 and no fault, push {heldPc, {line halfword 0, heldHalf}, 0}, clear heldValid, and not decode the beat further.
REQ-016 SHALL, when heldValid and the accepted beat has fetchPc!=heldPc+2, drop the held half and process the beat per REQ-012..014.
REQ-017 SHALL, on an accepted beat with fetchFault=1, push {fetchPc, 32'h0, 1} and clear heldValid; the line content is ignored.
REQ-018 SHALL drive outValid = (count != 0); pop on outValid && outReady; outPc/outInsn/outFault are the head entry, held stable while not popped.
REQ-019 SHALL support push and pop in the same cycle when not full, leaving count unchanged.
REQ-020 SHALL keep read and write pointers of log2(DEPTH) bits wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-021 SHALL, on flush, zero count and both pointers and clear heldValid next edge, ignore any beat or pop that cycle, and hold outValid=0 the following cycle.
REQ-022 SHALL have push-to-outValid latency of exactly 1 cycle, with no combinational path from fetch inputs to outputs.

Reset
REQ-023 SHALL on rst set count=0, pointers=0, heldValid=0, heldPc=0, heldHalf=0, so outValid=0 and fetchStall=0 the cycle after; outPc/outInsn/outFault are don't-care while outValid=0.
REQ-024 SHALL give rst priority over flush and all handshakes; rst asserted mid-straddle discards the held half.

Configuration
REQ-025 SHALL compile compressed-instruction support only when INSN_BUFFER_RVC_EN is defined: with it REQ-011..016 apply.
REQ-026 SHALL, without INSN_BUFFER_RVC_EN, push {fetchPc, the 32-bit word at fetchPc[log2(LINE_WIDTH/8)-1:2], 0} for every non-fault beat; fetchPc[1] is ignored and no held-half logic is synthesised.

Verification
REQ-027 SHALL cover: reset, then beat pc=0x1000, line word0=0x00000013 -> next cycle outValid=1, outPc=0x1000, outInsn=0x00000013, outFault=0.
REQ-028 SHALL cover (RVC_EN): beat pc=0x100E, halfword7=0x0513; then beat pc=0x1010, halfword0=0x0000 -> one entry outPc=0x100E, outInsn=0x00000513.
REQ-029 SHALL cover (RVC_EN): beat pc=0x2002, halfword1=0x4501 -> outInsn=0x00004501, outPc=0x2002.
REQ-030 SHALL cover: outReady=0 with DEPTH=2 and two beats pushed -> fetchStall=1, third beat not pushed; one pop -> fetchStall=0 next cycle and third beat accepted on re-presentation.
REQ-031 SHALL cover: flush with 2 entries queued and heldValid=1 -> outValid=0 next cycle; beat pc=0x3000 then yields outPc=0x3000.
REQ-032 SHALL cover: beat pc=0x4000 with fetchFault=1 -> outFault=1, outInsn=0, outPc=0x4000.

Source files
------------

// File: rtl/insn_buffer.sv
// Instruction buffer: slices fetched I-cache lines into 32-bit decode entries held in a small FIFO.
// Define INSN_BUFFER_RVC_EN to add compressed-instruction extraction, including straddling a line boundary.
module insn_buffer #(
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetchValid,
    input  logic                  fetchFault,
    input  logic [31:0]           fetchPc,
    input  logic [LINE_WIDTH-1:0] fetchLine,
    output logic                  fetchStall,
    input  logic                  flush,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [31:0]           outPc,
    output logic [31:0]           outInsn,
    output logic                  outFault
);

    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int WORDS = LINE_WIDTH / 32;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] mem_pc_q    [DEPTH];
    logic [31:0] mem_pc_d    [DEPTH];
    logic [31:0] mem_insn_q  [DEPTH];
    logic [31:0] mem_insn_d  [DEPTH];
    logic        mem_fault_q [DEPTH];
    logic        mem_fault_d [DEPTH];

    logic        accept;
    logic        pop;
    logic        push;
    logic [31:0] push_pc;
    logic [31:0] push_insn;
    logic        push_fault;

    // Handshake terms come from registered count only, so no fetch input reaches an output.
    assign fetchStall = (count_q == CNT_W'(DEPTH));
    assign outValid   = (count_q != '0);
    assign accept     = fetchValid && !fetchStall && !flush;
    assign pop        = outValid && outReady && !flush;

`ifdef INSN_BUFFER_RVC_EN
    localparam int HALVES = LINE_WIDTH / 16;
    localparam int HW_W   = OFF_W - 1;

    logic [15:0]     line_half [HALVES];
    logic [HW_W-1:0] h0_idx;
    logic [HW_W-1:0] h1_idx;
    logic [15:0]     h0;
    logic [15:0]     h1;
    logic            h0_last;
    logic            h0_wide;

    logic        held_valid_q, held_valid_d;
    logic [31:0] held_pc_q, held_pc_d;
    logic [15:0] held_half_q, held_half_d;

    for (genvar g = 0; g < HALVES; g++) begin : g_half
        assign line_half[g] = fetchLine[g*16 +: 16];
    end

    always_comb begin
        h0_idx       = fetchPc[OFF_W-1:1];
        h1_idx       = h0_idx + HW_W'(1);
        h0           = line_half[h0_idx];
        h1           = line_half[h1_idx];
        h0_last      = (h0_idx == '1);
        h0_wide      = (h0[1:0] == 2'b11);
        push         = 1'b0;
        push_pc      = fetchPc;
        push_insn    = '0;
        push_fault   = 1'b0;
        held_valid_d = held_valid_q;
        held_pc_d    = held_pc_q;
        held_half_d  = held_half_q;
        if (flush) begin
            held_valid_d = 1'b0;
        end else if (accept) begin
            if (fetchFault) begin
                push         = 1'b1;
                push_fault   = 1'b1;
                held_valid_d = 1'b0;
            end else if (held_valid_q && (fetchPc == held_pc_q + 32'd2)) begin
                // Continuation beat only supplies the upper half of the straddling instruction.
                push         = 1'b1;
                push_pc      = held_pc_q;
                push_insn    = {line_half[0], held_half_q};
                held_valid_d = 1'b0;
            end else if (h0_wide && h0_last) begin
                held_valid_d = 1'b1;
                held_pc_d    = fetchPc;
                held_half_d  = h0;
            end else begin
                push         = 1'b1;
                push_insn    = h0_wide ? {h1, h0} : {16'h0, h0};
                held_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid_q <= 1'b0;
            held_pc_q    <= '0;
            held_half_q  <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_pc_q    <= held_pc_d;
            held_half_q  <= held_half_d;
        end
    end
`else
    logic [31:0] line_word [WORDS];

    for (genvar g = 0; g < WORDS; g++) begin : g_word
        assign line_word[g] = fetchLine[g*32 +: 32];
    end

    always_comb begin
        push       = accept;
        push_pc    = fetchPc;
        push_insn  = fetchFault ? '0 : line_word[fetchPc[OFF_W-1:2]];
        push_fault = fetchFault;
    end
`endif

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        mem_pc_d    = mem_pc_q;
        mem_insn_d  = mem_insn_q;
        mem_fault_d = mem_fault_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]    = push_pc;
                mem_insn_d[wr_ptr_q]  = push_insn;
                mem_fault_d[wr_ptr_q] = push_fault;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: outputs are don't-care while outValid is low.
    always_ff @(posedge clk) begin
        mem_pc_q    <= mem_pc_d;
        mem_insn_q  <= mem_insn_d;
        mem_fault_q <= mem_fault_d;
    end

    assign outPc    = mem_pc_q[rd_ptr_q];
    assign outInsn  = mem_insn_q[rd_ptr_q];
    assign outFault = mem_fault_q[rd_ptr_q];

endmodule

// File: tb/tb_insn_buffer.sv
// Scoreboard bench for insn_buffer: directed beats queue expected entries, a negedge monitor checks pops.
module tb_insn_buffer;

    localparam int LW    = 128;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        fault;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetchValid = 1'b0;
    logic          fetchFault = 1'b0;
    logic [31:0]   fetchPc = '0;
    logic [LW-1:0] fetchLine = '0;
    logic          flush = 1'b0;
    logic          outReady = 1'b1;
    logic          fetchStall;
    logic          outValid;
    logic [31:0]   outPc;
    logic [31:0]   outInsn;
    logic          outFault;

    int     checks = 0;
    int     failures = 0;
    logic   mon_en = 1'b0;
    entry_t sb[$];
    entry_t mon_e;
    logic [LW-1:0] l1;

    insn_buffer #(.LINE_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetchValid (fetchValid),
        .fetchFault (fetchFault),
        .fetchPc    (fetchPc),
        .fetchLine  (fetchLine),
        .fetchStall (fetchStall),
        .flush      (flush),
        .outValid   (outValid),
        .outReady   (outReady),
        .outPc      (outPc),
        .outInsn    (outInsn),
        .outFault   (outFault)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_w(input int unsigned idx, input logic [31:0] w);
        logic [LW-1:0] l;
        l = '0;
        l[idx*32 +: 32] = w;
        return l;
    endfunction

    function automatic logic [LW-1:0] line_h(input int unsigned idx, input logic [15:0] h);
        logic [LW-1:0] l;
        l = '0;
        l[idx*16 +: 16] = h;
        return l;
    endfunction

    // Present one beat until it is taken; called just after a rising edge, returns just after one.
    task automatic send(input logic [31:0] pc, input logic [LW-1:0] line, input logic flt,
                        input logic exp_en, input logic [31:0] epc, input logic [31:0] einsn,
                        input logic efault);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b1;
        fetchValid = 1'b1;
        fetchPc    = pc;
        fetchLine  = line;
        fetchFault = flt;
        @(negedge clk);
        while (fetchStall) begin
            n++;
            if (n > 40) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout pc=%h stall actual=1 expected=0", pc);
        end
        @(posedge clk);
        #1;
        fetchValid = 1'b0;
        fetchFault = 1'b0;
        if (ok && exp_en) sb.push_back('{epc, einsn, efault});
    endtask

    task automatic sendx(input logic [31:0] pc, input logic [LW-1:0] line, input logic flt,
                         input logic [31:0] epc, input logic [31:0] einsn, input logic efault);
        send(pc, line, flt, 1'b1, epc, einsn, efault);
    endtask

    task automatic sendn(input logic [31:0] pc, input logic [LW-1:0] line);
        send(pc, line, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        outReady = 1'b1;
        while ((sb.size() != 0 || outValid) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check32("drain_sb_empty", sb.size(), 32'd0);
        check1("drain_outvalid", outValid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && !flush && outValid && outReady) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out pc=%h insn=%h fault=%b expected=none", outPc, outInsn, outFault);
            end else begin
                mon_e = sb.pop_front();
                check32("out_pc", outPc, mon_e.pc);
                check32("out_insn", outInsn, mon_e.insn);
                check1("out_fault", outFault, mon_e.fault);
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check1("rst_outvalid", outValid, 1'b0);
        check1("rst_stall", fetchStall, 1'b0);
        @(posedge clk);
        #1;

        // Basic word extraction with one-cycle latency.
        sendx(32'h1000, line_w(0, 32'h0000_0013), 1'b0, 32'h1000, 32'h0000_0013, 1'b0);
        @(negedge clk);
        check1("latency_outvalid", outValid, 1'b1);
        @(posedge clk);
        #1;
        drain();

        // Back-to-back beats selecting different words (push and pop in the same cycle).
        l1 = line_w(0, 32'h0000_0F13) | line_w(1, 32'h0BB7_0023) |
             line_w(2, 32'h89AB_CDE3) | line_w(3, 32'h1234_5677);
        sendx(32'h1008, l1, 1'b0, 32'h1008, 32'h89AB_CDE3, 1'b0);
        sendx(32'h100C, l1, 1'b0, 32'h100C, 32'h1234_5677, 1'b0);
`ifdef INSN_BUFFER_RVC_EN
        sendx(32'h1006, l1, 1'b0, 32'h1006, 32'hCDE3_0BB7, 1'b0);
`else
        sendx(32'h1006, l1, 1'b0, 32'h1006, 32'h0BB7_0023, 1'b0);
`endif
        sendx(32'h1004, l1, 1'b0, 32'h1004, 32'h0BB7_0023, 1'b0);
        drain();

        // Faulting beat ignores line content.
        sendx(32'h4000, {LW{1'b1}}, 1'b1, 32'h4000, 32'h0, 1'b1);
        drain();

`ifdef INSN_BUFFER_RVC_EN
        sendn(32'h100E, line_h(7, 16'h0513));
        @(negedge clk);
        check1("held_no_push", outValid, 1'b0);
        @(posedge clk);
        #1;
        sendx(32'h1010, line_h(0, 16'h0000), 1'b0, 32'h100E, 32'h0000_0513, 1'b0);
        sendx(32'h2002, line_h(1, 16'h4501), 1'b0, 32'h2002, 32'h0000_4501, 1'b0);
        sendn(32'h210E, line_h(7, 16'h0003));
        sendx(32'h2200, line_w(0, 32'h0000_0013), 1'b0, 32'h2200, 32'h0000_0013, 1'b0);
        sendn(32'h220E, line_h(7, 16'h0007));
        sendx(32'h2210, {LW{1'b1}}, 1'b1, 32'h2210, 32'h0, 1'b1);
        sendx(32'h2212, line_h(1, 16'h0001), 1'b0, 32'h2212, 32'h0000_0001, 1'b0);
        sendx(32'h230E, line_h(7, 16'h4501), 1'b0, 32'h230E, 32'h0000_4501, 1'b0);
        drain();
`endif

        // Backpressure: fill, hold a third beat, release one entry.
        outReady = 1'b0;
        sendx(32'h1100, line_w(0, 32'h00A0_0093), 1'b0, 32'h1100, 32'h00A0_0093, 1'b0);
        sendx(32'h1104, line_w(1, 32'h00C0_0193), 1'b0, 32'h1104, 32'h00C0_0193, 1'b0);
        fetchValid = 1'b1;
        fetchPc    = 32'h1108;
        fetchLine  = line_w(2, 32'h00B0_0113);
        @(negedge clk);
        check1("full_stall_a", fetchStall, 1'b1);
        check32("full_head_stable", outPc, 32'h1100);
        @(posedge clk);
        #1;
        @(negedge clk);
        check1("full_stall_b", fetchStall, 1'b1);
        check1("full_outvalid", outValid, 1'b1);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        @(negedge clk);
        check1("full_stall_pop_cycle", fetchStall, 1'b1);
        @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        check1("after_pop_stall", fetchStall, 1'b0);
        check32("after_pop_head", outPc, 32'h1104);
        @(posedge clk);
        sb.push_back('{32'h1108, 32'h00B0_0113, 1'b0});
        #1;
        fetchValid = 1'b0;
        @(negedge clk);
        check1("refill_stall", fetchStall, 1'b1);
        @(posedge clk);
        #1;
        drain();

        // Flush with queued entries (and a held half when RVC is built in).
        outReady = 1'b0;
        sendn(32'h1200, line_w(0, 32'h00A0_0093));
        sendn(32'h120E, line_w(3, 32'h0003_0000));
        @(negedge clk);
        check1("pre_flush_outvalid", outValid, 1'b1);
        @(posedge clk);
        #1;
        flush      = 1'b1;
        outReady   = 1'b1;
        fetchValid = 1'b1;
        fetchPc    = 32'h5000;
        fetchLine  = line_w(0, 32'h0000_0013);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        fetchValid = 1'b0;
        @(negedge clk);
        check1("flush_outvalid", outValid, 1'b0);
        check1("flush_stall", fetchStall, 1'b0);
        @(posedge clk);
        #1;
        sendx(32'h1210, line_w(0, 32'h0000_0001), 1'b0, 32'h1210, 32'h0000_0001, 1'b0);
        sendx(32'h3000, line_w(0, 32'h0000_0013), 1'b0, 32'h3000, 32'h0000_0013, 1'b0);
        drain();

        // Reset mid-operation wins over flush and a concurrent beat.
        outReady = 1'b0;
        sendn(32'h1300, line_w(0, 32'h0000_0093));
        sendn(32'h130E, line_w(3, 32'h0003_0000));
        rst        = 1'b1;
        flush      = 1'b1;
        fetchValid = 1'b1;
        fetchPc    = 32'h5000;
        fetchLine  = line_w(0, 32'h0000_0013);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        flush      = 1'b0;
        fetchValid = 1'b0;
        @(negedge clk);
        check1("rst2_outvalid", outValid, 1'b0);
        check1("rst2_stall", fetchStall, 1'b0);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        sendx(32'h1310, line_w(0, 32'h0000_0001), 1'b0, 32'h1310, 32'h0000_0001, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
